// File: rtl/if_id_decode_reg_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | if_id_decode_reg_if : Fetch->Decode bus (fetch/hazard inputs, decode outputs)
// | Rev 1.0
// +-----------------------------------------------------------------------------
interface if_id_decode_reg_if #(
  parameter int XLEN = 32
);
  logic [31:0]     InstrF;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCPlus4F;
  logic            ValidF;
  logic            StallD;
  logic            FlushD;

  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;
  logic [2:0]      ImmSrcD;
  logic [24:0]     ImmDataD;
  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic [4:0]      RdD;
  logic            IllegalD;

  modport master (
    output InstrF, PCF, PCPlus4F, ValidF, StallD, FlushD,
    input  InstrD, PCD, PCPlus4D, ValidD, ImmSrcD, ImmDataD,
           Rs1D, Rs2D, RdD, IllegalD
  );

  modport slave (
    input  InstrF, PCF, PCPlus4F, ValidF, StallD, FlushD,
    output InstrD, PCD, PCPlus4D, ValidD, ImmSrcD, ImmDataD,
           Rs1D, Rs2D, RdD, IllegalD
  );
endinterface
`default_nettype wire

// File: rtl/if_id_decode_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | if_id_decode_reg : IF/ID pipeline register with stall, flush and imm decode
// | Rev 1.0
// +-----------------------------------------------------------------------------
module if_id_decode_reg #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  if_id_decode_reg_if.slave bus
);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;

  logic [31:0]     instr_q,   instr_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [XLEN-1:0] pcplus4_q, pcplus4_d;
  logic            valid_q,   valid_d;

  // Flush beats stall: a squashed instruction must never be held in Decode.
  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (bus.FlushD) begin
      instr_d   = NOP_INSTR;
      pc_d      = '0;
      pcplus4_d = '0;
      valid_d   = 1'b0;
    end else if (!bus.StallD) begin
      instr_d   = bus.InstrF;
      pc_d      = bus.PCF;
      pcplus4_d = bus.PCPlus4F;
      valid_d   = bus.ValidF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_f7b5;
  logic [2:0] w_imm_src;
  logic       w_unsupported;

  assign w_opcode = instr_q[6:0];
  assign w_funct3 = instr_q[14:12];
  assign w_f7b5   = instr_q[30];

  always_comb begin
    w_imm_src     = 3'b111;
    w_unsupported = 1'b0;
    case (w_opcode)
      c_OP_LOAD, c_OP_JALR: w_imm_src = 3'b000;
      c_OP_IMM: begin
        if (w_funct3 == 3'b001)
          w_imm_src = 3'b110;
        else if (w_funct3 == 3'b101)
          w_imm_src = w_f7b5 ? 3'b101 : 3'b110;
        else
          w_imm_src = 3'b000;
      end
      c_OP_STORE:           w_imm_src = 3'b001;
      c_OP_BRANCH:          w_imm_src = 3'b010;
      c_OP_JAL:             w_imm_src = 3'b011;
      c_OP_LUI, c_OP_AUIPC: w_imm_src = 3'b100;
      c_OP_RTYPE:           w_imm_src = 3'b111;
      default: begin
        w_imm_src     = 3'b111;
        w_unsupported = 1'b1;
      end
    endcase
  end

  assign bus.InstrD   = instr_q;
  assign bus.PCD      = pc_q;
  assign bus.PCPlus4D = pcplus4_q;
  assign bus.ValidD   = valid_q;
  assign bus.ImmSrcD  = w_imm_src;
  assign bus.ImmDataD = instr_q[31:7];
  assign bus.Rs1D     = instr_q[19:15];
  assign bus.Rs2D     = instr_q[24:20];
  assign bus.RdD      = instr_q[11:7];
  // Bubbles carry no instruction, so they can never be flagged illegal.
  assign bus.IllegalD = valid_q & w_unsupported;

endmodule
`default_nettype wire
